// File: rtl/split_mem_pkg.sv
// Shared types and constants for the split-transaction memory target.
package split_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_ACK  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_SEND = 3'd5
  } smt_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int DEFAULT_READ_LATENCY = 8;

endpackage

// File: rtl/split_mem_target_byte_ram.sv
// Single-port byte RAM: synchronous write, synchronous registered read.
module byte_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // NOTE: the array has no reset; a reset would turn it into thousands of
  // flops instead of a RAM macro, and its contents are undefined at power-up.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/split_mem_target.sv
// Responder end of the split-transaction bus: in-place writes, deferred reads
// answered after a fixed latency once the bus is granted back.
module split_mem_target
  import split_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_in,
  input  logic        addr_in_valid,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  input  logic        rw,
  input  logic        split_grant,
  output logic        ready,
  output logic        ack,
  output logic        split_ack,
  output logic [7:0]  data_out,
  output logic        data_out_valid,
  output logic        split_req
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  smt_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic                  split_ack_q, split_ack_d;
  logic [7:0]            data_out_q, data_out_d;
  logic                  data_out_valid_q, data_out_valid_d;
  logic                  split_req_q, split_req_d;

  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_rdata;

  generate
    if (ADDR_WIDTH < 16) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr_in[15:ADDR_WIDTH];
    end
  endgenerate

  byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(data_in),
    .rdata(mem_rdata)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    split_ack_d = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = addr_q;

    case (state_q)
      S_IDLE: begin
        // A write with data in the address cycle goes straight to the RAM.
        mem_addr = addr_in[ADDR_WIDTH-1:0];
        if (addr_in_valid) begin
          addr_d = addr_in[ADDR_WIDTH-1:0];
          if (rw == RW_WRITE) begin
            if (data_in_valid) begin
              mem_we  = 1'b1;
              state_d = S_WR_ACK;
            end else begin
              state_d = S_WR_DATA;
            end
          end else begin
            cnt_d       = CNT_LOAD;
            split_ack_d = 1'b1;
            state_d     = S_RD_WAIT;
          end
        end
      end

      S_WR_DATA: begin
        if (data_in_valid) begin
          mem_we  = 1'b1;
          state_d = S_WR_ACK;
        end
      end

      S_WR_ACK: state_d = S_IDLE;

      S_RD_WAIT: begin
        // The RAM is read throughout the wait so its registered output
        // already holds the byte when the grant arrives; nothing can write
        // while a read is pending, so the value stays current.
        mem_re = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_RD_REQ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RD_REQ: begin
        mem_re = 1'b1;
        if (split_grant) begin
          data_out_d = mem_rdata;
          state_d    = S_RD_SEND;
        end
      end

      S_RD_SEND: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state presents.
    ready_d          = (state_d == S_IDLE);
    ack_d            = (state_d == S_WR_ACK) || (state_d == S_RD_SEND);
    data_out_valid_d = (state_d == S_RD_SEND);
    split_req_d      = (state_d == S_RD_REQ) || (state_d == S_RD_SEND);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      cnt_q            <= '0;
      ready_q          <= 1'b1;
      ack_q            <= 1'b0;
      split_ack_q      <= 1'b0;
      data_out_q       <= 8'h00;
      data_out_valid_q <= 1'b0;
      split_req_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      cnt_q            <= cnt_d;
      ready_q          <= ready_d;
      ack_q            <= ack_d;
      split_ack_q      <= split_ack_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      split_req_q      <= split_req_d;
    end
  end

  assign ready          = ready_q;
  assign ack            = ack_q;
  assign split_ack      = split_ack_q;
  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign split_req      = split_req_q;

endmodule

// File: tb/tb_split_mem_target.sv
// Randomized self-checking bench for split_mem_target against a
// transaction-level model (byte array keyed by aliased address).
module tb_split_mem_target;
  import split_mem_pkg::*;

  localparam int AW    = 12;
  localparam int LAT   = 8;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr_in;
  logic        addr_in_valid;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        rw;
  logic        split_grant;
  logic        ready;
  logic        ack;
  logic        split_ack;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        split_req;

  split_mem_target #(
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr_in       (addr_in),
    .addr_in_valid (addr_in_valid),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .rw            (rw),
    .split_grant   (split_grant),
    .ready         (ready),
    .ack           (ack),
    .split_ack     (split_ack),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .split_req     (split_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_mem [int];
  int         written [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int gap);
    int k;
    k = int'(a) % DEPTH;
    check("wr_ready_before", 32'(ready), 1);
    addr_in       = a;
    rw            = RW_WRITE;
    addr_in_valid = 1'b1;
    data_in       = d;
    data_in_valid = (gap == 0);
    tick();
    addr_in_valid = 1'b0;
    data_in_valid = 1'b0;
    addr_in       = 16'($urandom);
    data_in       = 8'($urandom);
    if (gap > 0) begin
      for (int i = 1; i < gap; i++) begin
        check("wr_wait_ack", 32'(ack), 0);
        tick();
      end
      check("wr_wait_ack", 32'(ack), 0);
      check("wr_wait_ready", 32'(ready), 0);
      data_in       = d;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
    end
    if (!model_mem.exists(k)) written.push_back(k);
    model_mem[k] = d;
    check("wr_ack", 32'(ack), 1);
    check("wr_ack_ready_low", 32'(ready), 0);
    check("wr_no_split_ack", 32'(split_ack), 0);
    check("wr_no_dov", 32'(data_out_valid), 0);
    tick();
    check("wr_ready_after", 32'(ready), 1);
    check("wr_ack_one_cycle", 32'(ack), 0);
  endtask

  task automatic do_read(input logic [15:0] a, input int gdelay, input int hold, input bit stray);
    int         k;
    logic [7:0] exp;
    k   = int'(a) % DEPTH;
    exp = model_mem[k];
    check("rd_ready_before", 32'(ready), 1);
    addr_in       = a;
    rw            = RW_READ;
    addr_in_valid = 1'b1;
    tick();
    addr_in_valid = 1'b0;
    check("rd_split_ack", 32'(split_ack), 1);
    check("rd_ready_low", 32'(ready), 0);
    check("rd_req_early", 32'(split_req), 0);
    for (int i = 1; i < LAT; i++) begin
      if (stray && i == 2) begin
        addr_in       = 16'($urandom);
        rw            = 1'($urandom);
        data_in       = 8'($urandom);
        addr_in_valid = 1'b1;
        data_in_valid = 1'b1;
        split_grant   = 1'b1;
      end
      tick();
      addr_in_valid = 1'b0;
      data_in_valid = 1'b0;
      split_grant   = 1'b0;
      check("rd_wait_req", 32'(split_req), 0);
      check("rd_wait_quiet", 32'(ack | split_ack | data_out_valid), 0);
    end
    tick();
    check("rd_req_high", 32'(split_req), 1);
    check("rd_req_no_ack", 32'(ack), 0);
    for (int i = 0; i < gdelay; i++) begin
      tick();
      check("rd_req_hold", 32'(split_req), 1);
      check("rd_req_no_ack", 32'(ack), 0);
    end
    split_grant = 1'b1;
    tick();
    split_grant = (hold >= 2);
    check("rd_dov", 32'(data_out_valid), 1);
    check("rd_ack", 32'(ack), 1);
    check("rd_req_under_grant", 32'(split_req), 1);
    check("rd_data", 32'(data_out), 32'(exp));
    tick();
    split_grant = (hold >= 3);
    check("rd_req_drop", 32'(split_req), 0);
    check("rd_ready_after", 32'(ready), 1);
    check("rd_ack_one_cycle", 32'(ack | data_out_valid), 0);
    check("rd_data_held", 32'(data_out), 32'(exp));
    tick();
    split_grant = 1'b0;
    check("rd_idle_grant_ignored", 32'(ack | split_req), 0);
  endtask

  task automatic reset_in_rd_req();
    addr_in       = 16'h0010;
    rw            = RW_READ;
    addr_in_valid = 1'b1;
    tick();
    addr_in_valid = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
    check("rst_pre_req", 32'(split_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_low", 32'(split_req), 0);
    check("rst_ready", 32'(ready), 1);
    check("rst_quiet", 32'(ack | split_ack | data_out_valid), 0);
    check("rst_data_out", 32'(data_out), 0);
    split_grant = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_ack", 32'(ack | data_out_valid), 0);
      check("post_rst_no_req", 32'(split_req), 0);
      check("post_rst_ready", 32'(ready), 1);
    end
    split_grant = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    addr_in       = '0;
    addr_in_valid = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    rw            = RW_READ;
    split_grant   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_ready", 32'(ready), 1);
    check("reset_ack", 32'(ack), 0);
    check("reset_split_ack", 32'(split_ack), 0);
    check("reset_dov", 32'(data_out_valid), 0);
    check("reset_split_req", 32'(split_req), 0);
    check("reset_data_out", 32'(data_out), 0);

    do_write(16'h0010, 8'hA5, 0);
    do_read(16'h0010, 0, 3, 1'b0);
    do_write(16'h1005, 8'h3C, 4);
    do_read(16'h0005, 1, 1, 1'b0);
    do_read(16'h0010, 2, 2, 1'b1);
    reset_in_rd_req();
    do_read(16'h0010, 0, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(16'($urandom), 8'($urandom), $urandom_range(0, 3));
      end else begin
        int k;
        k = written[$urandom_range(0, written.size() - 1)];
        do_read(16'(k) | (16'($urandom_range(0, 15)) << 12),
                $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
